// File: rtl/vga_pkg.sv
// vga_pkg: shared constants for the VGA timing generator.
// Holds the default 640x480@60 geometry, the derived line/frame totals,
// the coordinate counter width and the frame counter width.
package vga_pkg;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int COORD_W     = 10;
  localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one axis (horizontal or vertical) of the VGA raster.
// A wrap counter over VISIBLE+FRONT+SYNC+BACK positions that advances when
// en is high, flags the enabled step out of the last position (wrap), and
// decodes the active window and the sync window from the current count.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int VISIBLE = DEF_H_VISIBLE,
  parameter int FRONT   = DEF_H_FRONT,
  parameter int SYNC    = DEF_H_SYNC,
  parameter int BACK    = DEF_H_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic               wrap,
  output logic               active,
  output logic               in_sync
);

  localparam int TOTAL = VISIBLE + FRONT + SYNC + BACK;

  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACTIVE_END = COORD_W'(VISIBLE);
  localparam logic [COORD_W-1:0] SYNC_FIRST = COORD_W'(VISIBLE + FRONT);
  localparam logic [COORD_W-1:0] SYNC_LAST  = COORD_W'(VISIBLE + FRONT + SYNC - 1);

  logic at_last;

  assign at_last = (count == LAST);
  assign wrap    = en & at_last;
  assign active  = (count < ACTIVE_END);
  assign in_sync = (count >= SYNC_FIRST) && (count <= SYNC_LAST);

  // Step the position on each enabled cycle, returning to 0 after the last one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (en) begin
      count <= at_last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing.sv
// vga_timing: VGA raster timing generator running at clk/2 pixel rate.
// Produces pixel coordinates, active-video and active-low sync strobes,
// and line/frame start pulses. Define VGA_FRAME_COUNTER_EN to get a live
// 16-bit completed-frame counter; otherwise frameCount is tied to 0.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   pixTick,
  output logic [COORD_W-1:0]     xOrd,
  output logic [COORD_W-1:0]     yOrd,
  output logic                   visible,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   lineStart,
  output logic                   frameStart,
  output logic [FRAME_CNT_W-1:0] frameCount
);

  logic running;
  logic h_wrap;
  logic h_active;
  logic h_in_sync;
  logic v_active;
  logic v_in_sync;
`ifdef VGA_FRAME_COUNTER_EN
  logic                   frame_end;
  logic [FRAME_CNT_W-1:0] frame_count_q;
`else
  logic                   unused_v_wrap;
`endif

  // Pixel-rate strobe toggles every clk; running latches on after reset release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pixTick <= 1'b0;
      running <= 1'b0;
    end else begin
      pixTick <= ~pixTick;
      running <= 1'b1;
    end
  end

  vga_axis_counter #(
    .VISIBLE (H_VISIBLE),
    .FRONT   (H_FRONT),
    .SYNC    (H_SYNC),
    .BACK    (H_BACK)
  ) u_h_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (pixTick),
    .count   (xOrd),
    .wrap    (h_wrap),
    .active  (h_active),
    .in_sync (h_in_sync)
  );

  vga_axis_counter #(
    .VISIBLE (V_VISIBLE),
    .FRONT   (V_FRONT),
    .SYNC    (V_SYNC),
    .BACK    (V_BACK)
  ) u_v_axis (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (h_wrap),
    .count   (yOrd),
`ifdef VGA_FRAME_COUNTER_EN
    .wrap    (frame_end),
`else
    .wrap    (unused_v_wrap),
`endif
    .active  (v_active),
    .in_sync (v_in_sync)
  );

  assign visible    = running & h_active & v_active;
  assign hsync      = ~(running & h_in_sync);
  assign vsync      = ~(running & v_in_sync);
  assign lineStart  = running & pixTick & (xOrd == '0);
  assign frameStart = lineStart & (yOrd == '0);

`ifdef VGA_FRAME_COUNTER_EN
  // Count frames completed, bumping on the pixel step out of the last raster position.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_count_q <= '0;
    end else if (frame_end) begin
      frame_count_q <= frame_count_q + 1'b1;
    end
  end

  assign frameCount = frame_count_q;
`else
  assign frameCount = '0;
`endif

endmodule

// File: doc/vga_timing.md
VGA_TIMING -- requirements
Module: vga_timing

Interface
REQ-001 Parameters, one per line as name, default, meaning:
- H_VISIBLE, 640, active pixels per line.
- H_FRONT, 16, front porch pixels.
- H_SYNC, 96, hsync pulse pixels.
- H_BACK, 48, back porch pixels.
- V_VISIBLE, 480, active lines.
- V_FRONT, 10, front porch lines.
- V_SYNC, 2, vsync pulse lines.
- V_BACK, 33, back porch lines.

REQ-002 Ports, one per line as name, direction, width, meaning. Clock is clk and reset is rst_n, synchronous, active-low.
- clk, in, 1, 50 MHz system clock.
- rst_n, in, 1, synchronous active-low reset.
- pixTick, out, 1, high on the last clk of each 2-clk pixel period.
- xOrd, out, 10, horizontal count, range 0..H_TOTAL-1.
- yOrd, out, 10, vertical count, range 0..V_TOTAL-1.
- visible, out, 1, active video.
- hsync, out, 1, horizontal sync, active low.
- vsync, out, 1, vertical sync, active low.
- lineStart, out, 1, one-clk pulse at the start of each line.
- frameStart, out, 1, one-clk pulse at the start of each frame.
- frameCount, out, 16, completed-frame counter.

Function
REQ-003 H_TOTAL is the sum of the four H_* parameters (800 by default); V_TOTAL is the sum of the four V_* parameters (525 by default).
REQ-004 pixTick is a register that toggles on every clk edge when out of reset; the pixel clock is clk/2 (25 MHz).
REQ-005 xOrd and yOrd are registers and change only on a clk edge where pixTick=1.
REQ-006 xOrd steps +1 per pixel; at H_TOTAL-1 it wraps to 0.
REQ-007 yOrd steps +1 only when xOrd wraps; at V_TOTAL-1, together with the xOrd wrap, it wraps to 0.
REQ-008 visible = running AND xOrd<H_VISIBLE AND yOrd<V_VISIBLE, decoded combinationally from registers, with zero latency relative to xOrd/yOrd.
REQ-009 hsync=0 iff running AND xOrd is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] ([656,751] by default); otherwise 1.
REQ-010 vsync=0 iff running AND yOrd is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC-1] ([490,491] by default); otherwise 1.
REQ-011 lineStart = running AND pixTick AND xOrd==0, giving exactly one clk per line.
REQ-012 frameStart = lineStart AND yOrd==0, giving exactly one clk per frame.
REQ-013 running is a register: 0 in reset, set to 1 on the first clk edge after rst_n rises, and held at 1 thereafter.
REQ-014 Line period is 1600 clks, frame period is 840000 clks, and each pixel lasts exactly 2 clks.
REQ-015 Counter widths: 10 bits each; no value ≥ H_TOTAL or ≥ V_TOTAL is ever produced.

Reset
REQ-016 While rst_n=0 at a clk edge, the block loads:
- pixTick=0
- xOrd=0, yOrd=0
- running=0
- frameCount=0
REQ-017 Consequently, during reset the outputs are visible=0, hsync=1, vsync=1, lineStart=0, frameStart=0.
REQ-018 Reset asserted mid-frame (any xOrd/yOrd) takes effect on the next clk edge; no partial line completes.
REQ-019 After release: the first edge sets running=1 and pixTick=1 with xOrd=yOrd=0, so frameStart=1 in that clk. The second edge moves xOrd to 1.

Configuration
REQ-020 Macro VGA_FRAME_COUNTER_EN, when defined: frameCount increments by 1 on the clk edge where pixTick=1, xOrd=H_TOTAL-1 and yOrd=V_TOTAL-1; it wraps 65535 to 0.
REQ-021 When VGA_FRAME_COUNTER_EN is undefined: frameCount is a constant 0, no counter flops are inferred, and the port remains present.

Structure
REQ-022 Shared package vga_pkg holds:
- default H_*/V_* constants;
- H_TOTAL and V_TOTAL;
- the coordinate width constant (10);
- the frame counter width (16).
REQ-023 One sub-module, vga_axis_counter, is instantiated twice (horizontal and vertical). It is a parameterized wrap counter with enable, a wrap output, and range decode for the active and sync windows.

Verification
REQ-024 Hold rst_n=0 for 5 clks: all outputs take the reset values of REQ-016/REQ-017.
REQ-025 Release reset: frameStart=1 in the first clk, then xOrd=1 after 2 clks; lineStart pulses recur every 1600 clks.
REQ-026 Over one line, hsync is low for exactly 192 consecutive clks, starting in the clk where xOrd becomes 656.
REQ-027 Over one frame (840000 clks):
- visible is high for 614400 clks total;
- visible is 0 at xOrd=640 and at yOrd=480;
- vsync is low for 3200 clks, starting at xOrd=0, yOrd=490.
REQ-028 Assert rst_n=0 at xOrd=300, yOrd=200: next clk gives xOrd=yOrd=0 and visible=0. Release: frameStart pulse in the first clk, then normal progression.
REQ-029 Frame counter: with VGA_FRAME_COUNTER_EN, run 3 frames and frameCount=3; force frameCount to 65535 and run 1 frame, and frameCount=0. Without the macro, frameCount=0 throughout.
